tower_slot_scheduler: RTL and testbench

Owns a table of NUM_SLOTS tower placements and time-shares the single tower bitmap renderer among them. Per pixel, it selects the tower rectangle covering the current pixel and drives the bitmap's offset and inside-rectangle inputs. Place and remove commands arrive over a valid/ready handshake. They are validated by a sequential scan and committed only at frame start, so no tower tears mid-frame.

---
 rtl/tower_slot_scheduler.sv | 261 ++++++++++++++++++++++++++
 tb/tb_tower_slot_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tower_slot_scheduler.sv
// tower_slot_scheduler: owns NUM_SLOTS tower placements and time-shares the
// single tower bitmap renderer among them. Place/remove commands are checked
// by a sequential scan and only committed at frame start, so a tower never
// tears mid-frame.
// Optional feature macro: TOWER_SCHED_COUNT_EN adds the occupiedCount output.
module tower_slot_scheduler #(
  parameter int NUM_SLOTS = 8,
  parameter int OBJ_W     = 28,
  parameter int OBJ_H     = 58,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic [10:0]                  pixelX,
  input  logic [10:0]                  pixelY,
  input  logic                         startOfFrame,
  input  logic                         cmdValid,
  output logic                         cmdReady,
  input  logic                         cmdOp,
  input  logic [10:0]                  cmdX,
  input  logic [10:0]                  cmdY,
  input  logic [$clog2(NUM_SLOTS)-1:0] cmdSlot,
  output logic                         doneValid,
  output logic [2:0]                   doneStatus,
  output logic [$clog2(NUM_SLOTS)-1:0] doneSlot,
  output logic                         insideRectangle,
  output logic [10:0]                  offsetX,
  output logic [10:0]                  offsetY,
  output logic [$clog2(NUM_SLOTS)-1:0] activeSlot
`ifdef TOWER_SCHED_COUNT_EN
  ,
  output logic [$clog2(NUM_SLOTS):0]   occupiedCount
`endif
);

  localparam int SW = $clog2(NUM_SLOTS);

  localparam logic [2:0] ST_OK    = 3'd0;
  localparam logic [2:0] ST_FULL  = 3'd1;
  localparam logic [2:0] ST_OVL   = 3'd2;
  localparam logic [2:0] ST_OOB   = 3'd3;
  localparam logic [2:0] ST_EMPTY = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SCAN       = 3'd1,
    S_WAIT_FRAME = 3'd2,
    S_COMMIT     = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  // Placement table
  logic [NUM_SLOTS-1:0]         slot_valid_q;
  logic [NUM_SLOTS-1:0][10:0]   slot_x_q;
  logic [NUM_SLOTS-1:0][10:0]   slot_y_q;

  // Command context
  state_t          state_q;
  logic            op_q;
  logic [10:0]     x_q;
  logic [10:0]     y_q;
  logic [SW-1:0]   tgt_q;
  logic [SW-1:0]   scan_k_q;
  logic            free_found_q;
  logic            overlap_q;
  logic            armed_q;
  logic [2:0]      status_q;
  logic            cmd_ready_q;
  logic            done_valid_q;
  logic [2:0]      done_status_q;
  logic [SW-1:0]   done_slot_q;

  // Pixel path registers and next-state values
  logic            inside_q, inside_d;
  logic [10:0]     off_x_q, off_x_d;
  logic [10:0]     off_y_q, off_y_d;
  logic [SW-1:0]   active_q, active_d;

  logic [11:0]     place_r_s, place_b_s;
  logic            oob_s;
  logic [11:0]     dx_s, dy_s, adx_s, ady_s;
  logic            ovl_hit_s;

`ifdef TOWER_SCHED_COUNT_EN
  logic [SW:0]     count_q;
  assign occupiedCount = count_q;
`endif

  assign cmdReady        = cmd_ready_q;
  assign doneValid       = done_valid_q;
  assign doneStatus      = done_status_q;
  assign doneSlot        = done_slot_q;
  assign insideRectangle = inside_q;
  assign offsetX         = off_x_q;
  assign offsetY         = off_y_q;
  assign activeSlot      = active_q;

  // Bounds check of an incoming place, 12-bit so the right/bottom edge cannot wrap
  always_comb begin
    place_r_s = {1'b0, cmdX} + 12'(OBJ_W);
    place_b_s = {1'b0, cmdY} + 12'(OBJ_H);
    oob_s     = (place_r_s > 12'(SCREEN_W)) || (place_b_s > 12'(SCREEN_H));
  end

  // Overlap test of the slot examined in the current scan cycle
  always_comb begin
    dx_s      = {1'b0, slot_x_q[scan_k_q]} - {1'b0, x_q};
    dy_s      = {1'b0, slot_y_q[scan_k_q]} - {1'b0, y_q};
    adx_s     = dx_s[11] ? (12'd0 - dx_s) : dx_s;
    ady_s     = dy_s[11] ? (12'd0 - dy_s) : dy_s;
    ovl_hit_s = slot_valid_q[scan_k_q] && (adx_s < 12'(OBJ_W)) && (ady_s < 12'(OBJ_H));
  end

  // Pixel cover search: descending loop so the lowest covering slot wins
  always_comb begin
    inside_d = 1'b0;
    off_x_d  = 11'd0;
    off_y_d  = 11'd0;
    active_d = active_q;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_valid_q[i] &&
          ({1'b0, pixelX} >= {1'b0, slot_x_q[i]}) &&
          ({1'b0, pixelX} <  ({1'b0, slot_x_q[i]} + 12'(OBJ_W))) &&
          ({1'b0, pixelY} >= {1'b0, slot_y_q[i]}) &&
          ({1'b0, pixelY} <  ({1'b0, slot_y_q[i]} + 12'(OBJ_H)))) begin
        inside_d = 1'b1;
        off_x_d  = pixelX - slot_x_q[i];
        off_y_d  = pixelY - slot_y_q[i];
        active_d = SW'(i);
      end else begin
        inside_d = inside_d;
      end
    end
  end

  // Pixel path output registers (one clock of latency)
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inside_q <= 1'b0;
      off_x_q  <= 11'd0;
      off_y_q  <= 11'd0;
      active_q <= '0;
    end else begin
      inside_q <= inside_d;
      off_x_q  <= off_x_d;
      off_y_q  <= off_y_d;
      active_q <= active_d;
    end
  end

  // Command FSM: accept, scan, wait for frame start, commit table, report
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      slot_valid_q  <= '0;
      slot_x_q      <= '0;
      slot_y_q      <= '0;
      op_q          <= 1'b0;
      x_q           <= 11'd0;
      y_q           <= 11'd0;
      tgt_q         <= '0;
      scan_k_q      <= '0;
      free_found_q  <= 1'b0;
      overlap_q     <= 1'b0;
      armed_q       <= 1'b0;
      status_q      <= ST_OK;
      cmd_ready_q   <= 1'b1;
      done_valid_q  <= 1'b0;
      done_status_q <= ST_OK;
      done_slot_q   <= '0;
`ifdef TOWER_SCHED_COUNT_EN
      count_q       <= '0;
`endif
    end else begin
      done_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmdValid) begin
            cmd_ready_q  <= 1'b0;
            op_q         <= cmdOp;
            x_q          <= cmdX;
            y_q          <= cmdY;
            tgt_q        <= cmdSlot;
            scan_k_q     <= '0;
            free_found_q <= 1'b0;
            overlap_q    <= 1'b0;
            armed_q      <= 1'b0;
            if (!cmdOp) begin
              if (oob_s) begin
                status_q <= ST_OOB;
                state_q  <= S_DONE;
              end else begin
                state_q  <= S_SCAN;
              end
            end else if (!slot_valid_q[cmdSlot]) begin
              status_q <= ST_EMPTY;
              state_q  <= S_DONE;
            end else begin
              status_q <= ST_OK;
              state_q  <= S_WAIT_FRAME;
            end
          end
        end
        S_SCAN: begin
          if (!slot_valid_q[scan_k_q] && !free_found_q) begin
            free_found_q <= 1'b1;
            tgt_q        <= scan_k_q;
          end
          if (ovl_hit_s) begin
            overlap_q <= 1'b1;
          end
          scan_k_q <= scan_k_q + SW'(1);
          if (scan_k_q == SW'(NUM_SLOTS - 1)) begin
            if (overlap_q || ovl_hit_s) begin
              status_q <= ST_OVL;
              state_q  <= S_DONE;
            end else if (!free_found_q && slot_valid_q[scan_k_q]) begin
              status_q <= ST_FULL;
              state_q  <= S_DONE;
            end else begin
              status_q <= ST_OK;
              armed_q  <= 1'b0;
              state_q  <= S_WAIT_FRAME;
            end
          end
        end
        S_WAIT_FRAME: begin
          // The entry cycle only arms; a frame pulse then moves on
          armed_q <= 1'b1;
          if (armed_q && startOfFrame) begin
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          slot_valid_q[tgt_q] <= !op_q;
          if (!op_q) begin
            slot_x_q[tgt_q] <= x_q;
            slot_y_q[tgt_q] <= y_q;
          end
`ifdef TOWER_SCHED_COUNT_EN
          count_q <= op_q ? (count_q - 1'b1) : (count_q + 1'b1);
`endif
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_valid_q  <= 1'b1;
          done_status_q <= status_q;
          done_slot_q   <= tgt_q;
          cmd_ready_q   <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: begin
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tower_slot_scheduler.sv
// Scoreboard bench for tower_slot_scheduler: the stimulus thread pushes the
// expected completion (status, slot, arrival cycle) for each command and a
// monitor process pops and compares it whenever doneValid is seen.
module tb_tower_slot_scheduler;
  localparam int N = 8;
  localparam logic [2:0] OK = 3'd0, FULL = 3'd1, OVL = 3'd2, OOB = 3'd3, EMP = 3'd4;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = 11'd0, pixelY = 11'd0;
  logic        startOfFrame = 1'b0;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic        cmdOp = 1'b0;
  logic [10:0] cmdX = 11'd0, cmdY = 11'd0;
  logic [2:0]  cmdSlot = 3'd0;
  logic        doneValid;
  logic [2:0]  doneStatus;
  logic [2:0]  doneSlot;
  logic        insideRectangle;
  logic [10:0] offsetX, offsetY;
  logic [2:0]  activeSlot;
`ifdef TOWER_SCHED_COUNT_EN
  logic [3:0]  occupiedCount;
`endif

  tower_slot_scheduler #(.NUM_SLOTS(N)) dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdX(cmdX), .cmdY(cmdY), .cmdSlot(cmdSlot),
    .doneValid(doneValid), .doneStatus(doneStatus), .doneSlot(doneSlot),
    .insideRectangle(insideRectangle), .offsetX(offsetX), .offsetY(offsetY),
    .activeSlot(activeSlot)
`ifdef TOWER_SCHED_COUNT_EN
    , .occupiedCount(occupiedCount)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] st;
    logic [2:0] slot;
    int         t;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pop the expected completion whenever the DUT reports one
  always @(negedge clk) begin
    exp_t e;
    if (resetN && doneValid) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got doneValid=1 status=%0d, required no completion", doneStatus);
      end else begin
        e = sbq.pop_front();
        chk("done_status", int'(doneStatus), int'(e.st));
        if (e.st == OK) chk("done_slot", int'(doneSlot), int'(e.slot));
        chk("done_cycle", cyc, e.t);
      end
    end
  end

  task automatic sof_at(input int t);
    while (cyc < t) @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic send(input logic op, input int x, input int y, input int slot, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    cmdOp = op; cmdX = 11'(x); cmdY = 11'(y); cmdSlot = 3'(slot); cmdValid = 1'b1;
    while (!cmdReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmdReady) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got cmdReady=0, required 1");
    end
    acc = cyc;
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got %0d pending completions, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  // lat: cycles from accept to doneValid; sof_off: frame pulse offset (0 = none)
  task automatic do_cmd(input logic op, input int x, input int y, input int slot,
                        input logic [2:0] st, input int eslot, input int lat, input int sof_off);
    int acc;
    exp_t e;
    send(op, x, y, slot, acc);
    e.st = st; e.slot = 3'(eslot); e.t = acc + lat;
    sbq.push_back(e);
    if (sof_off > 0) sof_at(acc + sof_off);
    wait_drain();
  endtask

  task automatic place_ok(input int x, input int y, input int eslot);
    do_cmd(1'b0, x, y, 0, OK, eslot, N + 5, N + 2);
  endtask

  task automatic pix(input int x, input int y, input int ein, input int ex, input int ey, input int es);
    @(negedge clk);
    pixelX = 11'(x); pixelY = 11'(y);
    @(negedge clk);
    chk("pix_inside", int'(insideRectangle), ein);
    chk("pix_offx", int'(offsetX), ex);
    chk("pix_offy", int'(offsetY), ey);
    chk("pix_active", int'(activeSlot), es);
  endtask

  logic [N-1:0][10:0] fx, fy;

  initial begin
    int acc;
    int seen;
    exp_t e;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    // Reset state
    chk("rst_ready", int'(cmdReady), 1);
    chk("rst_done_valid", int'(doneValid), 0);
    chk("rst_done_status", int'(doneStatus), 0);
    chk("rst_done_slot", int'(doneSlot), 0);
    chk("rst_inside", int'(insideRectangle), 0);
`ifdef TOWER_SCHED_COUNT_EN
    chk("rst_count", int'(occupiedCount), 0);
`endif
    pix(113, 229, 0, 0, 0, 0);

    // First place: pulse on WAIT_FRAME entry is ignored, the next one commits
    send(1'b0, 100, 200, 0, acc);
    e.st = OK; e.slot = 3'd0; e.t = acc + N + 6;
    sbq.push_back(e);
    sof_at(acc + N + 1);
    sof_at(acc + N + 3);
    wait_drain();
    pix(113, 229, 1, 13, 29, 0);

    do_cmd(1'b0, 620, 10, 0, OOB, 0, 2, 0);
    do_cmd(1'b0, 127, 257, 0, OVL, 0, N + 2, 0);
    place_ok(128, 200, 1);
    place_ok(0, 422, 2);
    do_cmd(1'b0, 0, 423, 0, OOB, 0, 2, 0);
    pix(127, 200, 1, 27, 0, 0);
    pix(150, 210, 1, 22, 10, 1);
    pix(5, 479, 1, 5, 57, 2);
    do_cmd(1'b1, 0, 0, 5, EMP, 5, 2, 0);

    // Fill the remaining slots, then FULL and OVERLAP-over-FULL
    place_ok(300, 0, 3);
    place_ok(300, 100, 4);
    place_ok(300, 200, 5);
    place_ok(400, 0, 6);
    place_ok(400, 100, 7);
`ifdef TOWER_SCHED_COUNT_EN
    chk("count_full", int'(occupiedCount), 8);
`endif
    do_cmd(1'b0, 500, 300, 0, FULL, 0, N + 2, 0);
    do_cmd(1'b0, 110, 210, 0, OVL, 0, N + 2, 0);
    pix(301, 1, 1, 1, 1, 3);
    do_cmd(1'b1, 0, 0, 3, OK, 3, 5, 2);
`ifdef TOWER_SCHED_COUNT_EN
    chk("count_removed", int'(occupiedCount), 7);
`endif
    pix(301, 1, 0, 0, 0, 3);
    pix(5, 430, 1, 5, 8, 2);
    place_ok(500, 300, 3);
    pix(510, 330, 1, 10, 30, 3);

    // Reset while a remove waits for frame start
    send(1'b1, 0, 0, 7, acc);
    repeat (2) @(negedge clk);
    seen = done_cnt;
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    sof_at(cyc + 2);
    sof_at(cyc + 2);
    repeat (10) @(negedge clk);
    chk("no_done_after_reset", done_cnt, seen);
    chk("rst2_done_slot", int'(doneSlot), 0);
    chk("rst2_ready", int'(cmdReady), 1);
    pix(510, 330, 0, 0, 0, 0);
    pix(113, 229, 0, 0, 0, 0);
`ifdef TOWER_SCHED_COUNT_EN
    chk("rst2_count", int'(occupiedCount), 0);
`endif

    // Back-door: two slots covering the same pixel, lowest index must win
    fx = '0; fy = '0;
    fx[0] = 11'd50; fx[1] = 11'd50; fy[0] = 11'd50; fy[1] = 11'd50;
    force dut.slot_x_q = fx;
    force dut.slot_y_q = fy;
    force dut.slot_valid_q = 8'b0000_0010;
    pix(60, 60, 1, 10, 10, 1);
    force dut.slot_valid_q = 8'b0000_0011;
    pix(60, 60, 1, 10, 10, 0);
    release dut.slot_valid_q;
    release dut.slot_x_q;
    release dut.slot_y_q;
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    pix(60, 60, 0, 0, 0, 0);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion of the run, required finish");
    $fatal(1, "timeout");
  end
endmodule
